// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 raster constants for the VGA scan-out path.
package vga_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } vga_color_t;

    localparam int unsigned CNT_W = 11;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_SCALE    = 2;

    // Clamp a scaled raster coordinate to the 8-bit framebuffer address range.
    function automatic logic [7:0] sat8(input logic [CNT_W-1:0] v);
        return (v > CNT_W'(255)) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/vga_delay.sv
// Fixed-depth shift register with synchronous clear; DEPTH = 0 degenerates to a wire.
module vga_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = ^{clk_i, clr_i};
        assign q_o = d_i;
    end else begin : g_pipe
        logic [DEPTH-1:0][WIDTH-1:0] stage_q;

        always_ff @(posedge clk_i) begin
            if (clr_i) begin
                stage_q <= '0;
            end else begin
                stage_q[0] <= d_i;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_scanout.sv
// Raster timing generator and framebuffer read side; syncs are delayed to match
// the frame-store read latency so colour and sync reach the pins together.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter int unsigned SCALE    = VGA_SCALE,
    parameter int unsigned READ_LAT = 1,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic       i_vga_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  vga_color_t i_color,
    output logic [7:0] o_pxlX,
    output logic [7:0] o_pxlY,
    output vga_color_t o_color,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_active,
    output logic       o_frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             act0, hs0, vs0, fs0;
    logic [3:0]       side_dly;
    logic             act_dly, hs_dly, vs_dly, fs_dly;

    vga_color_t color_q;
    logic       active_q, hsync_q, vsync_q, fs_q;

    always_comb begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
        v_cnt_d = v_cnt_q;
        if (!i_enable) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_vga_clk) begin
        if (i_rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        act0 = i_enable && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs0  = i_enable && (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
        vs0  = i_enable && (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
        fs0  = i_enable && (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Read addresses are combinational so the frame store sees them in the counter cycle.
    assign o_pxlX = act0 ? sat8(h_cnt_q >> SCALE) : '0;
    assign o_pxlY = act0 ? sat8(v_cnt_q >> SCALE) : '0;

    vga_delay #(
        .WIDTH (4),
        .DEPTH (READ_LAT)
    ) u_side_dly (
        .clk_i (i_vga_clk),
        .clr_i (i_rst),
        .d_i   ({act0, hs0, vs0, fs0}),
        .q_o   (side_dly)
    );

    assign {act_dly, hs_dly, vs_dly, fs_dly} = side_dly;

    always_ff @(posedge i_vga_clk) begin
        if (i_rst) begin
            color_q  <= '0;
            active_q <= 1'b0;
            hsync_q  <= ~SYNC_POL;
            vsync_q  <= ~SYNC_POL;
            fs_q     <= 1'b0;
        end else begin
            color_q  <= act_dly ? i_color : '0;
            active_q <= act_dly;
            hsync_q  <= hs_dly ? SYNC_POL : ~SYNC_POL;
            vsync_q  <= vs_dly ? SYNC_POL : ~SYNC_POL;
            fs_q     <= fs_dly;
        end
    end

    assign o_color       = color_q;
    assign o_active      = active_q;
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: default, shrunk-raster and READ_LAT 0/3 instances share reset/enable.
module tb_vga_scanout;
    import vga_pkg::*;

    localparam vga_color_t COL = 12'hF0A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int ncyc       = 0;

    // default instance
    logic [7:0] px, py;
    vga_color_t col;
    logic hs, vs, act, fs;
    // small raster instance
    logic [7:0] px_f, py_f;
    vga_color_t col_f;
    logic hs_f, vs_f, act_f, fs_f;
    // READ_LAT 0, SCALE 0
    logic [7:0] px_0, py_0;
    vga_color_t col_0, fb_0;
    logic hs_0, vs_0, act_0, fs_0;
    // READ_LAT 3
    logic [7:0] px_3, py_3;
    vga_color_t col_3;
    vga_color_t fb_3 [3];
    logic hs_3, vs_3, act_3, fs_3;

    function automatic vga_color_t key(input logic [7:0] x, input logic [7:0] y);
        vga_color_t c;
        c.r = x[3:0];
        c.g = y[3:0];
        c.b = x[7:4];
        return c;
    endfunction

    assign fb_0 = key(px_0, py_0);
    always @(posedge clk) begin
        fb_3[0] <= key(px_3, py_3);
        fb_3[1] <= fb_3[0];
        fb_3[2] <= fb_3[1];
    end

    vga_scanout dut (
        .i_vga_clk(clk), .i_rst(rst), .i_enable(en), .i_color(COL),
        .o_pxlX(px), .o_pxlY(py), .o_color(col), .o_hsync(hs), .o_vsync(vs),
        .o_active(act), .o_frame_start(fs)
    );

    vga_scanout #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_f (
        .i_vga_clk(clk), .i_rst(rst), .i_enable(en), .i_color(COL),
        .o_pxlX(px_f), .o_pxlY(py_f), .o_color(col_f), .o_hsync(hs_f), .o_vsync(vs_f),
        .o_active(act_f), .o_frame_start(fs_f)
    );

    vga_scanout #(.READ_LAT(0), .SCALE(0)) dut_l0 (
        .i_vga_clk(clk), .i_rst(rst), .i_enable(en), .i_color(fb_0),
        .o_pxlX(px_0), .o_pxlY(py_0), .o_color(col_0), .o_hsync(hs_0), .o_vsync(vs_0),
        .o_active(act_0), .o_frame_start(fs_0)
    );

    vga_scanout #(.READ_LAT(3)) dut_l3 (
        .i_vga_clk(clk), .i_rst(rst), .i_enable(en), .i_color(fb_3[2]),
        .o_pxlX(px_3), .o_pxlY(py_3), .o_color(col_3), .o_hsync(hs_3), .o_vsync(vs_3),
        .o_active(act_3), .o_frame_start(fs_3)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            ncyc++;
        end
    endtask

    task automatic goto(input int t);
        while (ncyc < t) step(1);
    endtask

    // Leaves the bench at cycle 0 of counting: counters at (0,0), reset just released.
    task automatic release_rst();
        rst = 1'b1;
        en  = 1'b1;
        step(2);
        rst  = 1'b0;
        ncyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        step(2);
        compared++;
        if ({px, py} !== 16'h0) begin
            mismatched++;
            $display("FAIL reset_pxl: got %h required 0000", {px, py});
        end
        compared++;
        if (col !== 12'h000) begin
            mismatched++;
            $display("FAIL reset_color: got %h required 000", col);
        end
        compared++;
        if ({act, fs, hs, vs} !== 4'b0011) begin
            mismatched++;
            $display("FAIL reset_side: got %b required 0011", {act, fs, hs, vs});
        end
        compared++;
        if ({act_f, fs_f, hs_f, vs_f} !== 4'b0011) begin
            mismatched++;
            $display("FAIL reset_side_f: got %b required 0011", {act_f, fs_f, hs_f, vs_f});
        end
        compared++;
        if ({act_0, fs_0, hs_0, vs_0} !== 4'b0011) begin
            mismatched++;
            $display("FAIL reset_side_l0: got %b required 0011", {act_0, fs_0, hs_0, vs_0});
        end
        compared++;
        if ({act_3, fs_3, hs_3, vs_3} !== 4'b0011) begin
            mismatched++;
            $display("FAIL reset_side_l3: got %b required 0011", {act_3, fs_3, hs_3, vs_3});
        end
    endtask

    task automatic test_pixels();
        logic [7:0] exp_x;
        release_rst();
        for (int i = 0; i <= 4; i++) begin
            goto(i);
            exp_x = (i == 4) ? 8'd1 : 8'd0;
            compared++;
            if (px !== exp_x) begin
                mismatched++;
                $display("FAIL pxlX_start[%0d]: got %0d required %0d", i, px, exp_x);
            end
            if (i == 1) begin
                compared++;
                if (act !== 1'b0) begin
                    mismatched++;
                    $display("FAIL active_early: got %b required 0", act);
                end
            end
            if (i == 2) begin
                compared++;
                if ({act, fs, col} !== {1'b1, 1'b1, COL}) begin
                    mismatched++;
                    $display("FAIL first_pixel: got %h required %h", {act, fs, col}, {1'b1, 1'b1, COL});
                end
            end
            if (i == 3) begin
                compared++;
                if (fs !== 1'b0) begin
                    mismatched++;
                    $display("FAIL fs_width: got %b required 0", fs);
                end
            end
        end
        goto(639);
        compared++;
        if (px !== 8'd159) begin
            mismatched++;
            $display("FAIL pxlX_last: got %0d required 159", px);
        end
        goto(640);
        compared++;
        if (px !== 8'd0) begin
            mismatched++;
            $display("FAIL pxlX_hblank: got %0d required 0", px);
        end
        goto(641);
        compared++;
        if ({act, col} !== {1'b1, COL}) begin
            mismatched++;
            $display("FAIL last_pixel: got %h required %h", {act, col}, {1'b1, COL});
        end
        goto(642);
        compared++;
        if ({act, col} !== 13'h0) begin
            mismatched++;
            $display("FAIL blank_pixel: got %h required 0000", {act, col});
        end
    endtask

    task automatic test_hsync();
        int fall1 = -1, rise1 = -1, fall2 = -1, lows = 0;
        logic prev;
        release_rst();
        prev = hs;
        for (int n = 0; n < 1600; n++) begin
            goto(n);
            if (hs === 1'b0) lows++;
            if (prev === 1'b1 && hs === 1'b0) begin
                if (fall1 < 0) fall1 = n;
                else if (fall2 < 0) fall2 = n;
            end
            if (prev === 1'b0 && hs === 1'b1 && rise1 < 0) rise1 = n;
            prev = hs;
        end
        compared++;
        if (fall1 != 658) begin
            mismatched++;
            $display("FAIL hsync_fall1: got %0d required 658", fall1);
        end
        compared++;
        if (rise1 != 754) begin
            mismatched++;
            $display("FAIL hsync_rise1: got %0d required 754", rise1);
        end
        compared++;
        if (fall2 != 1458) begin
            mismatched++;
            $display("FAIL hsync_fall2: got %0d required 1458", fall2);
        end
        compared++;
        if (lows != 192) begin
            mismatched++;
            $display("FAIL hsync_low_cycles: got %0d required 192", lows);
        end
    endtask

    // Small raster: 80 clocks/line, 47 lines/frame, 3760 clocks/frame, vsync on lines 42-43.
    task automatic test_frame();
        int fs1 = -1, fs2 = -1, fs_cnt = 0, vlow = 0, vfall = -1;
        logic prev;
        release_rst();
        prev = vs_f;
        for (int n = 0; n <= 3762; n++) begin
            goto(n);
            if (fs_f === 1'b1) begin
                fs_cnt++;
                if (fs1 < 0) fs1 = n;
                else if (fs2 < 0) fs2 = n;
            end
            if (vs_f === 1'b0) vlow++;
            if (prev === 1'b1 && vs_f === 1'b0 && vfall < 0) vfall = n;
            prev = vs_f;
            if (n == 3120 || n == 3183) begin
                compared++;
                if (py_f !== 8'd9) begin
                    mismatched++;
                    $display("FAIL pxlY_last_row@%0d: got %0d required 9", n, py_f);
                end
            end
            if (n == 3184 || n == 3200 || n == 3400) begin
                compared++;
                if (py_f !== 8'd0) begin
                    mismatched++;
                    $display("FAIL pxlY_blank@%0d: got %0d required 0", n, py_f);
                end
            end
        end
        compared++;
        if (fs1 != 2 || fs2 != 3762) begin
            mismatched++;
            $display("FAIL frame_start_pos: got %0d,%0d required 2,3762", fs1, fs2);
        end
        compared++;
        if (fs_cnt != 2) begin
            mismatched++;
            $display("FAIL frame_start_count: got %0d required 2", fs_cnt);
        end
        compared++;
        if (vlow != 160) begin
            mismatched++;
            $display("FAIL vsync_low_cycles: got %0d required 160", vlow);
        end
        compared++;
        if (vfall != 3362) begin
            mismatched++;
            $display("FAIL vsync_fall: got %0d required 3362", vfall);
        end
    endtask

    task automatic test_midline_reset();
        int fs1 = -1, fs2 = -1;
        release_rst();
        goto(430);
        compared++;
        if ({px_f, py_f, act_f, col_f} !== {8'd7, 8'd1, 1'b1, COL}) begin
            mismatched++;
            $display("FAIL pre_reset_f: got %h required %h", {px_f, py_f, act_f, col_f}, {8'd7, 8'd1, 1'b1, COL});
        end
        rst = 1'b1;
        step(1);
        compared++;
        if ({px, py, col} !== 28'h0) begin
            mismatched++;
            $display("FAIL midrst_data: got %h required 0", {px, py, col});
        end
        compared++;
        if ({act, fs, hs, vs} !== 4'b0011) begin
            mismatched++;
            $display("FAIL midrst_side: got %b required 0011", {act, fs, hs, vs});
        end
        compared++;
        if ({px_f, py_f, col_f} !== 28'h0) begin
            mismatched++;
            $display("FAIL midrst_data_f: got %h required 0", {px_f, py_f, col_f});
        end
        compared++;
        if ({act_f, fs_f, hs_f, vs_f} !== 4'b0011) begin
            mismatched++;
            $display("FAIL midrst_side_f: got %b required 0011", {act_f, fs_f, hs_f, vs_f});
        end
        rst  = 1'b0;
        ncyc = 0;
        for (int n = 0; n <= 3762; n++) begin
            goto(n);
            if (fs_f === 1'b1) begin
                if (fs1 < 0) fs1 = n;
                else if (fs2 < 0) fs2 = n;
            end
        end
        compared++;
        if (fs1 != 2 || fs2 != 3762) begin
            mismatched++;
            $display("FAIL midrst_frame_start: got %0d,%0d required 2,3762", fs1, fs2);
        end
    endtask

    task automatic test_enable();
        release_rst();
        goto(100);
        en = 1'b0;
        goto(101);
        compared++;
        if (act !== 1'b1) begin
            mismatched++;
            $display("FAIL en_drop_lag: got %b required 1", act);
        end
        goto(102);
        compared++;
        if ({act, col, px} !== 21'h0) begin
            mismatched++;
            $display("FAIL en_drop_blank: got %h required 0", {act, col, px});
        end
        goto(700);
        compared++;
        if ({act, hs, vs, px} !== {1'b0, 1'b1, 1'b1, 8'd0}) begin
            mismatched++;
            $display("FAIL en_held: got %h required %h", {act, hs, vs, px}, {1'b0, 1'b1, 1'b1, 8'd0});
        end
        en   = 1'b1;
        ncyc = 0;
        goto(1);
        compared++;
        if (act !== 1'b0) begin
            mismatched++;
            $display("FAIL en_rise_early: got %b required 0", act);
        end
        goto(2);
        compared++;
        if ({act, fs, col} !== {1'b1, 1'b1, COL}) begin
            mismatched++;
            $display("FAIL en_rise_first: got %h required %h", {act, fs, col}, {1'b1, 1'b1, COL});
        end
        goto(4);
        compared++;
        if (px !== 8'd1) begin
            mismatched++;
            $display("FAIL en_rise_pxlX: got %0d required 1", px);
        end
        goto(657);
        compared++;
        if (hs !== 1'b1) begin
            mismatched++;
            $display("FAIL en_rise_hs_pre: got %b required 1", hs);
        end
        goto(658);
        compared++;
        if (hs !== 1'b0) begin
            mismatched++;
            $display("FAIL en_rise_hs_fall: got %b required 0", hs);
        end
    endtask

    task automatic test_latency();
        int h, x;
        logic       e_act;
        vga_color_t e_col;
        release_rst();
        for (int n = 0; n <= 645; n++) begin
            goto(n);
            // READ_LAT 0 / SCALE 0: pin shows h = n-1, x clamped at 255
            h = n - 1;
            e_act = (h >= 0 && h < 640);
            x = (h > 255) ? 255 : h;
            e_col = e_act ? key(8'(x), 8'd0) : 12'h000;
            compared++;
            if ({act_0, col_0} !== {e_act, e_col}) begin
                mismatched++;
                $display("FAIL lat0@%0d: got %h required %h", n, {act_0, col_0}, {e_act, e_col});
            end
            // READ_LAT 3 / SCALE 2: pin shows h = n-4
            h = n - 4;
            e_act = (h >= 0 && h < 640);
            x = (h < 0) ? 0 : h / 4;
            e_col = e_act ? key(8'(x), 8'd0) : 12'h000;
            compared++;
            if ({act_3, col_3} !== {e_act, e_col}) begin
                mismatched++;
                $display("FAIL lat3@%0d: got %h required %h", n, {act_3, col_3}, {e_act, e_col});
            end
        end
    endtask

    initial begin
        test_reset();
        test_pixels();
        test_hsync();
        test_frame();
        test_midline_reset();
        test_enable();
        test_latency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
Raster timing generator and read side of the VGA frame store. Runs on the VGA pixel clock and sweeps horizontal/vertical counters over the full line/frame, including blanking. Drives the 8-bit framebuffer read coordinates (pxlX/pxlY) and takes back the looked-up vga_color_t. Emits colour plus hsync/vsync, delay-matched to the framebuffer read latency, so pixel data and syncs reach the pins on the same cycle.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SCALE, 2, log2 of screen pixels per framebuffer pixel, applied on each axis
READ_LAT, 1, framebuffer read latency in i_vga_clk cycles, from pxlX/pxlY to i_color; legal range 0..4
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
i_vga_clk  in  1  pixel clock; the only clock
i_rst  in  1  synchronous reset, active-high
i_enable  in  1  raster run enable
i_color  in  vga_color_t  framebuffer read data, valid READ_LAT cycles after o_pxlX/o_pxlY
o_pxlX  out  8  framebuffer read column
o_pxlY  out  8  framebuffer read row
o_color  out  vga_color_t  pixel colour to DAC; zero while blanked
o_hsync  out  1  horizontal sync
o_vsync  out  1  vertical sync
o_active  out  1  high while o_color is a visible pixel
o_frame_start  out  1  one-cycle pulse, pin-aligned with pixel (0,0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1) are registered, 11 bits wide.
- Stepping:
  - h_cnt increments every cycle while enabled.
  - At h_cnt == H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt == V_TOTAL-1 together with the h wrap, v_cnt wraps to 0.
- Stage 0 (counter cycle):
  - act0 = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs0 = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs0 = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - fs0 = (h_cnt == 0 && v_cnt == 0).
- Coordinates:
  - o_pxlX = act0 ? sat8(h_cnt >> SCALE) : 0; o_pxlY = act0 ? sat8(v_cnt >> SCALE) : 0.
  - sat8 clamps any value above 255 to 255.
  - These are combinational from the counter registers, so no extra latency.
- Sideband alignment: {act0, hs0, vs0, fs0} pass through a READ_LAT-deep register pipeline, which lines them up with i_color.
- Output register: one final stage registers all pin outputs.
  - o_color = act_d ? i_color : 0.
  - o_hsync = hs_d ? SYNC_POL : ~SYNC_POL; o_vsync likewise from vs_d.
  - o_active = act_d; o_frame_start = fs_d.
- Latency: counter state to pins = READ_LAT+1 cycles (2 by default).
- Reset (i_rst high at a clock edge, any time, including mid-line):
  - Next cycle: h_cnt = v_cnt = 0, all pipeline stages cleared.
  - o_color = 0, o_active = 0, o_frame_start = 0, o_hsync = o_vsync = ~SYNC_POL.
  - After release, counting starts at (0,0); the first visible pixel reaches the pins READ_LAT+1 cycles after the first counting cycle.
- i_enable low: counters forced to 0 and held; stage-0 sidebands forced inactive (act0 = hs0 = vs0 = fs0 = 0). The pipeline keeps draining, so the pins go blank/sync-inactive within READ_LAT+1 cycles.
- i_enable rising: behaves like reset release.
- Simultaneous i_rst and i_enable: reset wins.
- No handshake with the frame store: reads are issued every cycle and i_color is trusted blindly, whether or not a write is in progress.

Decomposition:
- Shared package vga_pkg holds:
  - vga_color_t (already defined there).
  - Default 640x480@60 timing constants (H_/V_ values above).
  - SCALE default.
- One sub-module, vga_delay: parameterised WIDTH/DEPTH shift register with synchronous clear. DEPTH = 0 is a pass-through. It carries the sideband pipeline.

Test Plan:
- Default parameters, release reset, i_color = {r:F, g:0, b:A}:
  - o_pxlX reads 0,0,0,0,1,... and is 159 at h = 639.
  - o_active rises exactly 2 cycles after release; o_color = {F,0,A} while active, 0 from pin cycle 642 of each line.
- hsync: o_hsync low for exactly 96 cycles per 800-cycle line, falling 658 cycles after each line start (656+2).
- Full frame: o_frame_start pulses every 420000 cycles; o_vsync low for exactly 1600 cycles (lines 490-491); o_pxlY reaches 119 at v = 479 and is 0 during vertical blanking.
- Mid-line reset: assert i_rst at h = 300, v = 100 for one cycle -> next cycle o_pxlX = o_pxlY = 0, o_color = 0, o_hsync = o_vsync = 1; the following frame_start arrives 420002 cycles after reset deassert.
- Enable drop: i_enable low at h = 100 -> o_active falls 2 cycles later and stays 0; re-raise -> timing identical to a fresh reset release.
- READ_LAT = 0 and READ_LAT = 3 builds: pin latency is 1 and 4 cycles respectively; the pixel with i_color keyed to o_pxlX matches its own coordinate at the pins (no smear across the boundary).
